neuron_layer_sequencer: RTL and testbench
=========================================

// Module: neuron_layer_sequencer
// PURPOSE
// - Time-multiplexes one shared multiply-accumulate unit across all neurons of a fully connected layer.
// - Computes each output as y[j] = ReLU(B[j] + sum_i x[i]*W[j][i]).
// - Fetches x, W and B from external synchronous-read memories.
// - Emits results one per neuron over a valid/ready stream.
// - Sits between the input-vector buffer and the next layer's input buffer.
// PARAMETERS
// - N_IN   4   inputs per neuron (>=1)
// - N_OUT  3   neurons in the layer (>=1)
// - DW     32  data/weight/bias/accumulator width, two's complement
// PORTS
// - clk     in   1                       rising-edge clock, single domain
// - rst     in   1                       synchronous reset, active-high
// - start   in   1                       begin layer; sampled only in IDLE
// - busy    out  1                       high from the cycle after start is accepted until done
// - done    out  1                       one-cycle pulse after the last result handshake
// - x_addr  out  $clog2(N_IN) (min 1)    input buffer address
// - x_data  in   DW                      x[x_addr], valid 1 cycle after address
// - w_addr  out  $clog2(N_IN*N_OUT) (min 1)  weight address = j*N_IN+i
// - w_data  in   DW                      W, valid 1 cycle after address
// - b_addr  out  $clog2(N_OUT) (min 1)   bias address = j
// - b_data  in   DW                      B[j], valid 1 cycle after address
// - y_valid out  1                       result j available
// - y_ready in   1                       downstream accepts
// - y_idx   out  $clog2(N_OUT) (min 1)   neuron index j of y_data
// - y_data  out  DW                      ReLU result
// BEHAVIOUR
// - Reset values:
//   - state = IDLE.
//   - busy, done, y_valid = 0.
//   - All addresses, y_idx, y_data and acc = 0.
// - FSM states: IDLE, BIAS, MAC, DRAIN, OUT.
// - Memory read latency is fixed at exactly one cycle; there is no memory stall input.
// - IDLE:
//   - On start=1: j <= 0, go to BIAS.
//   - start is ignored in every other state; no queuing.
// - BIAS (1 cycle): drive b_addr = j; go to MAC with i = 0.
// - MAC (N_IN cycles, i = 0..N_IN-1):
//   - Drive x_addr = i and w_addr = j*N_IN + i.
//   - In the first MAC cycle: acc <= b_data.
//   - In each later MAC cycle: acc <= acc + x_data*w_data (the product for i-1).
//   - After i = N_IN-1, go to DRAIN.
// - DRAIN (1 cycle):
//   - acc <= acc + product for i = N_IN-1.
//   - The ReLU is applied to this final sum and registered: y_data <= (signed sum > 0) ? sum : 0.
//   - y_idx <= j; y_valid <= 1; go to OUT.
// - OUT: hold y_valid, y_data and y_idx stable until y_valid && y_ready.
//   - On that handshake: y_valid <= 0.
//   - If j == N_OUT-1: assert done for one cycle, busy <= 0, go to IDLE.
//   - Otherwise: j <= j+1, go to BIAS.
// - Throughput with y_ready held high: N_IN+3 cycles per neuron.
//   - start is accepted in cycle 0; done is asserted in cycle N_OUT*(N_IN+3)+1.
// - Arithmetic:
//   - The product keeps its low DW bits.
//   - The sum wraps modulo 2^DW; there is no saturation.
//   - The ReLU compare is signed; a sum of exactly 0 outputs 0.
// - Boundaries:
//   - N_IN = 1: MAC lasts 1 cycle.
//   - N_OUT = 1: done follows the first handshake.
//   - y_ready is allowed high before y_valid; the handshake counts only while in OUT.
//   - rst asserted in any state aborts the layer next edge and restores reset values.
//     - No partial y is emitted and no done pulse occurs.
// STRUCTURE
// - Package nn_pkg:
//   - localparam DW.
//   - typedef enum logic [2:0] seq_state_t {IDLE, BIAS, MAC, DRAIN, OUT}.
//   - function relu(input logic [DW-1:0] s).
// - Sub-module neuron_mac:
//   - Holds the registered acc.
//   - Controls: load_bias, mac_en.
//   - Computes the combinational ReLU of acc + x*w for the DRAIN register.
// - All counters (i, j) and the FSM stay in neuron_layer_sequencer.
// TESTING
// - Setup for tests 1, 3, 4 and 5: N_IN=4, N_OUT=3, x={1,2,3,4}, y_ready=1.
//   - W0={1,1,1,1}, B0=0; W1={-1,-1,-1,-1}, B1=5; W2={0,0,0,0}, B2=0.
// - 1. Basic run -> y=(0,10),(1,0),(2,0).
//   - Neuron 1 sums to -5; neuron 2 sums to exactly 0.
//   - done in cycle 22 after start; busy low the cycle after.
// - 2. Overflow: x={0x4000_0000,0,0,0}, W0={4,...}, B0=0 -> product wraps to 0, y0=0.
//   - Separately, B0=0x7FFF_FFFF with +1 -> y0=0, since the wrapped sum is negative.
// - 3. Backpressure: hold y_ready=0 for 5 cycles in OUT for neuron 0.
//   - y_valid, y_idx and y_data (=10) stay constant.
//   - Neuron 1 fetch (b_addr=1) starts only after the handshake.
// - 4. Ignored start: pulse start during MAC of neuron 1 -> sequence and results unchanged, exactly one done.
// - 5. Reset mid-operation:
//   - Assert rst during MAC of neuron 1 -> next cycle all outputs at reset values, no done.
//   - Then start again -> full correct result set as in test 1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron layer sequencer.
//   DW          : data/weight/bias/accumulator width (two's complement)
//   seq_state_t : sequencer FSM state encoding
//   relu()      : signed rectified-linear clamp, zero maps to zero
package nn_pkg;

    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } seq_state_t;

    // Negative and zero sums both clamp to zero.
    function automatic logic [DW-1:0] relu(input logic [DW-1:0] s);
        return ($signed(s) > $signed(DW'(0))) ? s : '0;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// Accumulator for one neuron at a time.
//   clk, rst             : clock, synchronous active-high reset
//   load_bias_i          : acc <= b_data_i (first MAC cycle)
//   mac_en_i             : acc <= acc + x_data_i*w_data_i
//   b_data_i/x_data_i/w_data_i : memory read data
//   relu_sum_c           : combinational ReLU(acc + x*w), captured by the sequencer in DRAIN
module neuron_mac
    import nn_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_bias_i,
    input  logic          mac_en_i,
    input  logic [DW-1:0] b_data_i,
    input  logic [DW-1:0] x_data_i,
    input  logic [DW-1:0] w_data_i,
    output logic [DW-1:0] relu_sum_c
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] prod_c;
    logic [DW-1:0] sum_c;

    // Low DW bits of the product are the same for signed and unsigned operands.
    assign prod_c     = x_data_i * w_data_i;
    assign sum_c      = acc_q + prod_c;
    assign relu_sum_c = relu(sum_c);

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (load_bias_i) begin
            acc_q <= b_data_i;
        end else if (mac_en_i) begin
            acc_q <= sum_c;
        end
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one MAC unit across all neurons of a fully connected layer,
// computing y[j] = ReLU(B[j] + sum_i x[i]*W[j][i]) and streaming results out.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a layer (only honoured in IDLE)
//   busy, done        : layer in progress / one-cycle completion pulse
//   x_addr/x_data     : input vector memory (1-cycle read latency)
//   w_addr/w_data     : weight memory, address j*N_IN+i
//   b_addr/b_data     : bias memory, address j
//   y_valid/y_ready   : result stream handshake
//   y_idx/y_data      : neuron index and ReLU result
module neuron_layer_sequencer
    import nn_pkg::*;
#(
    parameter  int unsigned N_IN  = 4,
    parameter  int unsigned N_OUT = 3,
    localparam int unsigned XAW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned WAW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int unsigned JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [XAW-1:0] x_addr,
    input  logic [DW-1:0]  x_data,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  w_data,
    output logic [JW-1:0]  b_addr,
    input  logic [DW-1:0]  b_data,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [JW-1:0]  y_idx,
    output logic [DW-1:0]  y_data
);

    seq_state_t     state_q;
    logic [XAW-1:0] i_q;
    logic [JW-1:0]  j_q;
    logic [JW-1:0]  j_d;
    logic           load_bias_c;
    logic           mac_en_c;
    logic [DW-1:0]  relu_sum_c;

    assign j_d = j_q + 1'b1;

    // Bias arrives in the first MAC cycle; products lag their address by one cycle,
    // so the last product is folded in during DRAIN.
    assign load_bias_c = (state_q == MAC) && (i_q == '0);
    assign mac_en_c    = ((state_q == MAC) && (i_q != '0)) || (state_q == DRAIN);

    neuron_mac u_mac (
        .clk         (clk),
        .rst         (rst),
        .load_bias_i (load_bias_c),
        .mac_en_i    (mac_en_c),
        .b_data_i    (b_data),
        .x_data_i    (x_data),
        .w_data_i    (w_data),
        .relu_sum_c  (relu_sum_c)
    );

    // Sequencer FSM with registered outputs; addresses are set on entry to the
    // state that presents them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            x_addr  <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
            y_valid <= 1'b0;
            y_idx   <= '0;
            y_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        j_q     <= '0;
                        b_addr  <= '0;
                        busy    <= 1'b1;
                        state_q <= BIAS;
                    end
                end
                BIAS: begin
                    i_q     <= '0;
                    x_addr  <= '0;
                    w_addr  <= WAW'(j_q) * WAW'(N_IN);
                    state_q <= MAC;
                end
                MAC: begin
                    if (i_q == XAW'(N_IN - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        i_q    <= i_q + 1'b1;
                        x_addr <= i_q + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    y_data  <= relu_sum_c;
                    y_idx   <= j_q;
                    y_valid <= 1'b1;
                    state_q <= OUT;
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (j_q == JW'(N_OUT - 1)) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            j_q     <= j_d;
                            b_addr  <= j_d;
                            state_q <= BIAS;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer (N_IN=4, N_OUT=3) with
// one-cycle-latency memory models and a handshake/done monitor.
module tb_neuron_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  x_addr;
    logic [31:0] x_data;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [1:0]  b_addr;
    logic [31:0] b_data;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  y_idx;
    logic [31:0] y_data;

    logic [31:0] xmem [4];
    logic [31:0] wmem [12];
    logic [31:0] bmem [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_busy;
    int res_idx [$];
    logic [31:0] res_data [$];
    logic [31:0] exp_basic [3] = '{32'd10, 32'd0, 32'd0};

    neuron_layer_sequencer #(.N_IN(4), .N_OUT(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .x_addr  (x_addr),
        .x_data  (x_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_idx   (y_idx),
        .y_data  (y_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories.
    always @(posedge clk) begin
        x_data <= xmem[x_addr];
        w_data <= wmem[w_addr];
        b_data <= bmem[b_addr];
        cyc    <= cyc + 1;
    end

    // Record handshakes and done pulses using pre-edge values.
    always @(posedge clk) begin
        if (!rst) begin
            if (y_valid && y_ready) begin
                res_idx.push_back(int'(y_idx));
                res_data.push_back(y_data);
            end
            if (done) begin
                done_cnt  = done_cnt + 1;
                done_cyc  = cyc;
                done_busy = busy;
            end
        end
    end

    task automatic setup();
        xmem = '{32'd1, 32'd2, 32'd3, 32'd4};
        wmem = '{32'd1, 32'd1, 32'd1, 32'd1,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd0, 32'd0, 32'd0, 32'd0};
        bmem = '{32'd0, 32'd5, 32'd0};
        y_ready = 1'b1;
    endtask

    task automatic start_layer();
        @(negedge clk);
        res_idx.delete();
        res_data.delete();
        done_cnt  = 0;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; y_ready = 1'b1;
        setup();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, y_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: got %b expected 000", {busy, done, y_valid});
        end
        checks++;
        if ({x_addr, w_addr, b_addr, y_idx} !== 10'd0) begin
            errors++; $display("FAIL reset_addr: got %h expected 0", {x_addr, w_addr, b_addr, y_idx});
        end
        checks++;
        if (y_data !== 32'd0) begin
            errors++; $display("FAIL reset_ydata: got %h expected 0", y_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        setup();
        start_layer();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", busy);
        end
        wait_done(40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL basic_timeout: got no done expected done");
        end
        checks++;
        if (done_cyc - start_cyc !== 22) begin
            errors++; $display("FAIL basic_done_cycle: got %0d expected 22", done_cyc - start_cyc);
        end
        checks++;
        if (done_busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy_at_done: got %b expected 0", done_busy);
        end
        checks++;
        if (res_idx.size() !== 3) begin
            errors++; $display("FAIL basic_count: got %0d expected 3", res_idx.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res_idx.size() <= k || res_idx[k] !== k || res_data[k] !== exp_basic[k]) begin
                errors++;
                $display("FAIL basic_y%0d: got idx %0d data %0d expected idx %0d data %0d",
                         k, (res_idx.size() > k) ? res_idx[k] : -1,
                         (res_data.size() > k) ? res_data[k] : 32'hDEAD, k, exp_basic[k]);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, done, done_cnt} !== {1'b0, 1'b0, 32'd1}) begin
            errors++; $display("FAIL basic_after: got busy %b done %b cnt %0d expected 0 0 1", busy, done, done_cnt);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        // Product 0x4000_0000*4 wraps to 0.
        setup();
        xmem = '{32'h4000_0000, 32'd0, 32'd0, 32'd0};
        wmem[0] = 32'd4; wmem[1] = 32'd4; wmem[2] = 32'd4; wmem[3] = 32'd4;
        start_layer();
        wait_done(40, ok);
        checks++;
        if (!ok || res_data.size() < 1 || res_data[0] !== 32'd0) begin
            errors++; $display("FAIL ovf_prod_wrap: got %h expected 0", (res_data.size() > 0) ? res_data[0] : 32'hDEAD);
        end
        // 0x7FFF_FFFF + 1 wraps negative, clamps to 0.
        setup();
        bmem[0] = 32'h7FFF_FFFF;
        xmem = '{32'd1, 32'd0, 32'd0, 32'd0};
        wmem[0] = 32'd1; wmem[1] = 32'd0; wmem[2] = 32'd0; wmem[3] = 32'd0;
        start_layer();
        wait_done(40, ok);
        checks++;
        if (!ok || res_data.size() < 1 || res_data[0] !== 32'd0) begin
            errors++; $display("FAIL ovf_sum_wrap: got %h expected 0", (res_data.size() > 0) ? res_data[0] : 32'hDEAD);
        end
        // Negative times negative: y0 = (-3)*(-2) = 6, y1 = 5 + (-3)*(-1) = 8.
        setup();
        xmem = '{32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0};
        wmem[0] = 32'hFFFF_FFFE;
        start_layer();
        wait_done(40, ok);
        checks++;
        if (!ok || res_data.size() < 2 || res_data[0] !== 32'd6 || res_data[1] !== 32'd8) begin
            errors++; $display("FAIL signed_mul: got %0d %0d expected 6 8",
                               (res_data.size() > 0) ? res_data[0] : 32'hDEAD,
                               (res_data.size() > 1) ? res_data[1] : 32'hDEAD);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        setup();
        y_ready = 1'b0;
        start_layer();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (y_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen || cyc - start_cyc !== 7) begin
            errors++; $display("FAIL bp_valid_cycle: got seen %b cycle %0d expected 1 7", seen, cyc - start_cyc);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({y_valid, y_idx, y_data, b_addr} !== {1'b1, 2'd0, 32'd10, 2'd0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid %b idx %0d data %0d b_addr %0d expected 1 0 10 0",
                         k, y_valid, y_idx, y_data, b_addr);
            end
            if (k < 5) @(negedge clk);
        end
        y_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({y_valid, b_addr, busy} !== {1'b0, 2'd1, 1'b1}) begin
            errors++; $display("FAIL bp_release: got valid %b b_addr %0d busy %b expected 0 1 1", y_valid, b_addr, busy);
        end
        wait_done(60, ok);
        checks++;
        if (!ok || done_cyc - start_cyc !== 27) begin
            errors++; $display("FAIL bp_done_cycle: got %0d expected 27", done_cyc - start_cyc);
        end
        checks++;
        if (res_data.size() !== 3 || res_data[0] !== 32'd10 || res_idx[2] !== 2) begin
            errors++; $display("FAIL bp_results: got count %0d expected 3 with y0=10", res_data.size());
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        setup();
        start_layer();
        repeat (9) @(negedge clk);
        checks++;
        if ({b_addr, w_addr} !== {2'd1, 4'd5}) begin
            errors++; $display("FAIL ign_in_mac1: got b_addr %0d w_addr %0d expected 1 5", b_addr, w_addr);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, ok);
        checks++;
        if (!ok || done_cyc - start_cyc !== 22) begin
            errors++; $display("FAIL ign_done_cycle: got %0d expected 22", done_cyc - start_cyc);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res_idx.size() <= k || res_idx[k] !== k || res_data[k] !== exp_basic[k]) begin
                errors++; $display("FAIL ign_y%0d: got count %0d expected idx %0d data %0d", k, res_idx.size(), k, exp_basic[k]);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL ign_single_done: got cnt %0d busy %b expected 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        setup();
        start_layer();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, y_valid, x_addr, w_addr, b_addr, y_idx, y_data} !== 45'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy %b done %b valid %b xa %0d wa %0d ba %0d idx %0d data %h expected all 0",
                     busy, done, y_valid, x_addr, w_addr, b_addr, y_idx, y_data);
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0 || res_idx.size() !== 1) begin
            errors++; $display("FAIL rstmid_aborted: got done_cnt %0d busy %b results %0d expected 0 0 1",
                               done_cnt, busy, res_idx.size());
        end
        start_layer();
        wait_done(40, ok);
        checks++;
        if (!ok || done_cyc - start_cyc !== 22) begin
            errors++; $display("FAIL rstmid_rerun_done: got %0d expected 22", done_cyc - start_cyc);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res_idx.size() <= k || res_idx[k] !== k || res_data[k] !== exp_basic[k]) begin
                errors++; $display("FAIL rstmid_y%0d: got count %0d expected idx %0d data %0d", k, res_idx.size(), k, exp_basic[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
